// File: rtl/alu_ex_stage.sv
// Execute stage: EX register -> 32-bit add/logic ALU -> EX/MEM register, valid/ready on both sides.
// Optional overflow trap on ADD/SUB is enabled by defining ALU_OVF_TRAP_EN.
module alu_ex_stage #(
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic [RD_W-1:0] in_rd,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_result,
   output logic [RD_W-1:0] out_rd,
   output logic            out_wen,
   output logic            out_zero,
   output logic            out_cout
`ifdef ALU_OVF_TRAP_EN
   ,
   output logic            out_ovf_exc
`endif
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0, OP_ADDU = 4'd1, OP_SUB = 4'd2, OP_SUBU = 4'd3,
      OP_AND  = 4'd4, OP_OR   = 4'd5, OP_XOR = 4'd6, OP_NOR  = 4'd7,
      OP_SLT  = 4'd8, OP_SLTU = 4'd9
   } op_e;

   logic            s1_valid_q, s1_valid_d;
   logic [3:0]      s1_op_q;
   logic [31:0]     s1_a_q, s1_b_q;
   logic [RD_W-1:0] s1_rd_q;

   logic            s2_valid_q, s2_valid_d;
   logic [31:0]     s2_result_q;
   logic [RD_W-1:0] s2_rd_q;
   logic            s2_wen_q, s2_zero_q, s2_cout_q, s2_ovf_q;

   logic            s1_adv, s2_adv, accept;

   logic [2:0]      alu_s;
   logic            alu_cin;
   logic [31:0]     alu_bx, alu_d;
   logic [32:0]     alu_sum;
   logic            alu_cout, alu_v;
   logic [31:0]     ex_result;
   logic            ex_wen, ex_ovf;

   assign s2_adv   = !s2_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = !s1_valid_q | s2_adv;
   assign accept   = in_valid & in_ready;

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      alu_s   = 3'b000;
      alu_cin = 1'b0;
      case (s1_op_q)
         OP_ADD, OP_ADDU:                  alu_s = 3'b010;
         OP_SUB, OP_SUBU, OP_SLT, OP_SLTU: begin alu_s = 3'b011; alu_cin = 1'b1; end
         OP_AND:                           alu_s = 3'b110;
         OP_OR:                            alu_s = 3'b100;
         OP_XOR:                           alu_s = 3'b000;
         OP_NOR:                           alu_s = 3'b101;
         default:                          alu_s = 3'b111;
      endcase
   end

   // Select 011 subtracts as A + ~B + Cin; the adder is shared by both arithmetic codes.
   always_comb begin
      alu_bx   = (alu_s == 3'b011) ? ~s1_b_q : s1_b_q;
      alu_sum  = {1'b0, s1_a_q} + {1'b0, alu_bx} + {32'd0, alu_cin};
      alu_d    = 32'd0;
      alu_cout = 1'b0;
      case (alu_s)
         3'b010, 3'b011: begin alu_d = alu_sum[31:0]; alu_cout = alu_sum[32]; end
         3'b110:         alu_d = s1_a_q & s1_b_q;
         3'b100:         alu_d = s1_a_q | s1_b_q;
         3'b000:         alu_d = s1_a_q ^ s1_b_q;
         3'b101:         alu_d = ~(s1_a_q | s1_b_q);
         default:        alu_d = 32'd0;
      endcase
      alu_v = (s1_a_q[31] == alu_bx[31]) & (alu_d[31] != s1_a_q[31]);
   end

   always_comb begin
      ex_result = alu_d;
      ex_wen    = 1'b1;
      ex_ovf    = 1'b0;
      case (s1_op_q)
         OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
         OP_AND, OP_OR, OP_XOR, OP_NOR: ex_result = alu_d;
         OP_SLT:  ex_result = {31'd0, alu_d[31] ^ alu_v};
         OP_SLTU: ex_result = {31'd0, ~alu_cout};
         default: begin ex_result = 32'd0; ex_wen = 1'b0; end
      endcase
`ifdef ALU_OVF_TRAP_EN
      if ((s1_op_q == OP_ADD || s1_op_q == OP_SUB) && alu_v) begin
         ex_ovf = 1'b1;
         ex_wen = 1'b0;
      end
`endif
   end

   // flush wins over any accept or advance on the same edge.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (accept)      s1_valid_d = 1'b1;
         else if (s1_adv) s1_valid_d = 1'b0;
         if (s1_adv)         s2_valid_d = 1'b1;
         else if (out_ready) s2_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= 4'd0;
         s1_a_q      <= 32'd0;
         s1_b_q      <= 32'd0;
         s1_rd_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= 32'd0;
         s2_rd_q     <= '0;
         s2_wen_q    <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_cout_q   <= 1'b0;
         s2_ovf_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (accept) begin
            s1_op_q <= in_op;
            s1_a_q  <= in_a;
            s1_b_q  <= in_b;
            s1_rd_q <= in_rd;
         end
         if (s1_adv) begin
            s2_result_q <= ex_result;
            s2_rd_q     <= s1_rd_q;
            s2_wen_q    <= ex_wen;
            s2_zero_q   <= (ex_result == 32'd0);
            s2_cout_q   <= alu_cout;
            s2_ovf_q    <= ex_ovf;
         end
      end
   end

   // Data registers may be stale after a flush; qualify the side-effecting bits with valid.
   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_rd     = s2_rd_q;
   assign out_wen    = s2_valid_q & s2_wen_q;
   assign out_zero   = s2_zero_q;
   assign out_cout   = s2_cout_q;
`ifdef ALU_OVF_TRAP_EN
   assign out_ovf_exc = s2_valid_q & s2_ovf_q;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: table of streamed ops plus stall, flush and reset sequences.
module tb_alu_ex_stage;

   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_op;
   logic [31:0]     in_a, in_b;
   logic [RD_W-1:0] in_rd;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_result;
   logic [RD_W-1:0] out_rd;
   logic            out_wen, out_zero, out_cout;
`ifdef ALU_OVF_TRAP_EN
   logic            out_ovf_exc;
`endif

   always #5 clk = ~clk;

   alu_ex_stage #(.RD_W(RD_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_wen(out_wen), .out_zero(out_zero), .out_cout(out_cout)
`ifdef ALU_OVF_TRAP_EN
      , .out_ovf_exc(out_ovf_exc)
`endif
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [31:0] result;
      logic        wen, zero;
      logic        chk_cout, cout;
      logic        ovf;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [RD_W-1:0] rd);
      in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd;
   endtask

   initial begin
      //            op     a             b             result        wen   zero  chkc  cout  ovf
      vec[0]  = '{4'd0,  32'h00000005, 32'h00000003, 32'h00000008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vec[1]  = '{4'd2,  32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vec[2]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[3]  = '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vec[4]  = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[5]  = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[6]  = '{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[7]  = '{4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[8]  = '{4'd12, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[9]  = '{4'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vec[10] = '{4'd3,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vec[11] = '{4'd8,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[12] = '{4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[13] = '{4'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vec[14] = '{4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ALU_OVF_TRAP_EN
      vec[15] = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      vec[15] = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

      reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
      #12;
      check("rst in_ready",   32'(in_ready),   32'd1);
      check("rst out_valid",  32'(out_valid),  32'd0);
      check("rst out_result", out_result,      32'd0);
      check("rst out_rd",     32'(out_rd),     32'd0);
      check("rst out_wen",    32'(out_wen),    32'd0);
      check("rst out_zero",   32'(out_zero),   32'd0);
      check("rst out_cout",   32'(out_cout),   32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Stream every vector back to back; vector c-1 is visible one edge after vector c is offered.
      for (int c = 0; c <= NV; c++) begin
         if (c < NV) begin
            drive(1'b1, vec[c].op, vec[c].a, vec[c].b, RD_W'(c + 1));
            check($sformatf("v%0d in_ready", c), 32'(in_ready), 32'd1);
         end else begin
            drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
         end
         tick();
         if (c >= 1) begin
            check($sformatf("v%0d valid", c - 1),  32'(out_valid), 32'd1);
            check($sformatf("v%0d result", c - 1), out_result, vec[c-1].result);
            check($sformatf("v%0d rd", c - 1),     32'(out_rd), 32'(c));
            check($sformatf("v%0d wen", c - 1),    32'(out_wen), 32'(vec[c-1].wen));
            check($sformatf("v%0d zero", c - 1),   32'(out_zero), 32'(vec[c-1].zero));
            if (vec[c-1].chk_cout)
               check($sformatf("v%0d cout", c - 1), 32'(out_cout), 32'(vec[c-1].cout));
`ifdef ALU_OVF_TRAP_EN
            check($sformatf("v%0d ovf", c - 1),    32'(out_ovf_exc), 32'(vec[c-1].ovf));
`endif
         end
      end
      tick();
      check("drain valid", 32'(out_valid), 32'd0);

      // Stall: three ops offered with out_ready low, only two fit.
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd10, 32'd1, 5'd20);
      check("stall A ready", 32'(in_ready), 32'd1);
      tick();
      drive(1'b1, 4'd2, 32'd10, 32'd1, 5'd21);
      check("stall B ready", 32'(in_ready), 32'd1);
      tick();
      check("stall A out", out_result, 32'd11);
      drive(1'b1, 4'd5, 32'd1, 32'd2, 5'd22);
      check("stall C ready", 32'(in_ready), 32'd0);
      tick();
      check("stall hold1 result", out_result, 32'd11);
      check("stall hold1 rd",     32'(out_rd), 32'd20);
      check("stall in_ready low", 32'(in_ready), 32'd0);
      drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
      tick();
      check("stall hold2 valid",  32'(out_valid), 32'd1);
      check("stall hold2 result", out_result, 32'd11);
      out_ready = 1'b1;
      tick();
      check("release B valid",  32'(out_valid), 32'd1);
      check("release B result", out_result, 32'd9);
      check("release B rd",     32'(out_rd), 32'd21);
      tick();
      check("release no dup",   32'(out_valid), 32'd0);

      // Flush with both stages full and a handshake on the flush edge.
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd1);
      tick();
      drive(1'b1, 4'd0, 32'd2, 32'd2, 5'd2);
      tick();
      drive(1'b1, 4'd0, 32'd3, 32'd3, 5'd3);
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
      check("flush valid", 32'(out_valid), 32'd0);
      check("flush wen",   32'(out_wen),   32'd0);
      tick();
      check("flush discard", 32'(out_valid), 32'd0);
      drive(1'b1, 4'd6, 32'h0000FFFF, 32'h00FF00FF, 5'd9);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
      tick();
      check("post-flush valid",  32'(out_valid), 32'd1);
      check("post-flush result", out_result, 32'h00FFFF00);
      check("post-flush rd",     32'(out_rd), 32'd9);
      check("post-flush wen",    32'(out_wen), 32'd1);

`ifdef ALU_OVF_TRAP_EN
      // SUB overflow also traps; SUBU does not.
      drive(1'b1, 4'd2, 32'h80000000, 32'h00000001, 5'd4);
      tick();
      drive(1'b1, 4'd3, 32'h80000000, 32'h00000001, 5'd5);
      tick();
      check("sub ovf exc",    32'(out_ovf_exc), 32'd1);
      check("sub ovf wen",    32'(out_wen), 32'd0);
      check("sub ovf result", out_result, 32'h7FFFFFFF);
      drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
      tick();
      check("subu no exc",    32'(out_ovf_exc), 32'd0);
      check("subu wen",       32'(out_wen), 32'd1);
      tick();
`endif

      // Asynchronous reset in the middle of an op.
      drive(1'b1, 4'd0, 32'd7, 32'd7, 5'd7);
      tick();
      drive(1'b1, 4'd0, 32'd8, 32'd8, 5'd8);
      tick();
      check("pre-reset valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async rst valid",  32'(out_valid), 32'd0);
      check("async rst result", out_result, 32'd0);
      check("async rst ready",  32'(in_ready), 32'd1);
      drive(1'b0, 4'd0, 32'd0, 32'd0, '0);
      tick();
      reset_n = 1'b1;
      tick();
      check("after rst valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
